// File: rtl/vec_indexer.sv
// vec_indexer
//   Sparse-vector-to-index decoder. Captures a VEC_LEN-bit sparse vector and
//   locates its lowest set bit with a coarse-to-fine search. It steps SEG bits
//   at a time, then BLK bits, then single bits. It also flags empty vectors and
//   vectors with more than one bit set. This is the inverse of the
//   index-to-vector generator.
//
// Parameters
//   VEC_LEN  vector length in bits; multiple of SEG, at most 16383
//   SEG      coarse stride in bits; multiple of BLK
//   BLK      mid stride in bits
//
// Ports
//   clk        in   rising-edge clock
//   rst_b      in   asynchronous active-low reset
//   start      in   request pulse; sampled only in IDLE
//   mode       in   0: search starts at BLK stride, 1: starts at SEG stride
//   vector     in   sparse input; bit i is index i; sampled on the accepting edge
//   busy       out  high whenever the FSM is not IDLE
//   done       out  one-cycle pulse; result valid
//   idx        out  index of the lowest set bit
//   err_empty  out  input vector was all zero
//   err_multi  out  more than one bit was set
module vec_indexer #(
  parameter int VEC_LEN = 9800,
  parameter int SEG     = 50,
  parameter int BLK     = 10
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start,
  input  logic               mode,
  input  logic [VEC_LEN-1:0] vector,
  output logic               busy,
  output logic               done,
  output logic [13:0]        idx,
  output logic               err_empty,
  output logic               err_multi
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S50  = 3'd1,
    S10  = 3'd2,
    S1   = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t             state_q;
  // Bit 0 of shreg_q is always the bit at position base_q of the captured vector.
  logic [VEC_LEN-1:0] shreg_q;
  logic [13:0]        base_q;
  logic               busy_q;
  logic               done_q;
  logic [13:0]        idx_q;
  logic               err_empty_q;
  logic               err_multi_q;

  assign busy      = busy_q;
  assign done      = done_q;
  assign idx       = idx_q;
  assign err_empty = err_empty_q;
  assign err_multi = err_multi_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      idx_q       <= '0;
      err_empty_q <= 1'b0;
      err_multi_q <= 1'b0;
    end else begin
      // done is a single-cycle pulse. It is raised only on the edge that enters DONE.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q     <= vector;
            base_q      <= '0;
            idx_q       <= '0;
            err_multi_q <= 1'b0;
            busy_q      <= 1'b1;
            // An empty vector skips the search entirely. This keeps every
            // search state guaranteed to find a set bit.
            if (vector == '0) begin
              err_empty_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              err_empty_q <= 1'b0;
              state_q     <= mode ? S50 : S10;
            end
          end
        end

        S50: begin
          if (shreg_q[SEG-1:0] == '0) begin
            shreg_q <= shreg_q >> SEG;
            base_q  <= base_q + 14'(SEG);
          end else begin
            state_q <= S10;
          end
        end

        S10: begin
          if (shreg_q[BLK-1:0] == '0) begin
            shreg_q <= shreg_q >> BLK;
            base_q  <= base_q + 14'(BLK);
          end else begin
            state_q <= S1;
          end
        end

        S1: begin
          if (!shreg_q[0]) begin
            shreg_q <= shreg_q >> 1;
            base_q  <= base_q + 14'd1;
          end else begin
            state_q <= CHK;
          end
        end

        CHK: begin
          // Bit 0 is the lowest set bit. Any other set bit above it means multi-hot.
          idx_q       <= base_q;
          err_multi_q <= |shreg_q[VEC_LEN-1:1];
          done_q      <= 1'b1;
          state_q     <= DONE;
        end

        DONE: begin
          // start is deliberately ignored here. A new request waits for IDLE.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_indexer.sv
// Testbench for vec_indexer. Each request pushes its expected result and
// latency to a scoreboard queue. The entry is popped and compared when done appears.
module tb_vec_indexer;

  localparam int VEC_LEN = 9800;
  localparam int SEG     = 50;
  localparam int BLK     = 10;
  localparam int BUDGET  = 1200;

  logic               clk   = 1'b0;
  logic               rst_b = 1'b1;
  logic               start = 1'b0;
  logic               mode  = 1'b0;
  logic [VEC_LEN-1:0] vector = '0;
  logic               busy;
  logic               done;
  logic [13:0]        idx;
  logic               err_empty;
  logic               err_multi;

  vec_indexer #(.VEC_LEN(VEC_LEN), .SEG(SEG), .BLK(BLK)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .mode      (mode),
    .vector    (vector),
    .busy      (busy),
    .done      (done),
    .idx       (idx),
    .err_empty (err_empty),
    .err_multi (err_multi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit empty;
    bit multi;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int lat_of(input int i, input bit m);
    if (m) return (i / 50) + ((i % 50) / 10) + (i % 10) + 4;
    return (i / 10) + (i % 10) + 3;
  endfunction

  function automatic logic [VEC_LEN-1:0] onehot(input int i);
    logic [VEC_LEN-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Issues one request and checks the result against the scoreboard.
  // When glitch > 0, a stray start carrying a different vector is presented on edge E0+glitch.
  // When sid = 1, start is also held high during the done cycle.
  task automatic req(input string tag, input logic [VEC_LEN-1:0] v, input bit m,
                     input int glitch, input bit sid);
    exp_t e;
    int   cnt;
    int   cyc;
    e.idx = 0;
    cnt   = 0;
    for (int k = 0; k < VEC_LEN; k++) begin
      if (v[k]) begin
        if (cnt == 0) e.idx = k;
        cnt++;
      end
    end
    e.empty = (cnt == 0);
    e.multi = (cnt > 1);
    e.lat   = e.empty ? 0 : lat_of(e.idx, m);

    @(negedge clk);
    vector = v;
    mode   = m;
    start  = 1'b1;
    sb.push_back(e);
    @(posedge clk);               // E0
    #1;
    start  = 1'b0;
    vector = onehot(3);           // input may change after acceptance
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);

    cyc = 0;
    while (!done && cyc < BUDGET) begin
      if (glitch > 0 && cyc + 1 == glitch) begin
        @(negedge clk);
        start  = 1'b1;
        vector = onehot(7);
        mode   = ~m;
        @(posedge clk);
        cyc++;
        #1;
        start  = 1'b0;
      end else begin
        @(posedge clk);
        cyc++;
        #1;
      end
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);

    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    chk({tag, "_idx"}, 32'(idx), 32'(e.idx));
    chk({tag, "_empty"}, 32'(err_empty), 32'(e.empty));
    chk({tag, "_multi"}, 32'(err_multi), 32'(e.multi));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);

    if (sid) begin
      @(negedge clk);
      start  = 1'b1;
      vector = onehot(3);
      mode   = 1'b0;
    end
    @(posedge clk);               // leaves DONE
    #1;
    start = 1'b0;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_idx_hold"}, 32'(idx), 32'(e.idx));
    chk({tag, "_empty_hold"}, 32'(err_empty), 32'(e.empty));
  endtask

  initial begin
    #1;
    rst_b = 1'b0;
    #11;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_empty", 32'(err_empty), 32'd0);
    chk("rst_multi", 32'(err_multi), 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;

    req("i0_m1",    onehot(0), 1'b1, 0, 1'b0);
    req("i137_m1",  onehot(137), 1'b1, 0, 1'b0);
    req("i137_m0",  onehot(137), 1'b0, 0, 1'b0);
    req("i9799_m1", onehot(9799), 1'b1, 0, 1'b0);
    req("i9799_m0", onehot(9799), 1'b0, 0, 1'b0);
    req("multi",    onehot(42) | onehot(5000), 1'b1, 0, 1'b0);
    req("multi_m0", onehot(9) | onehot(10), 1'b0, 0, 1'b0);
    req("empty",    '0, 1'b1, 0, 1'b1);
    req("i500_gl",  onehot(500), 1'b1, 3, 1'b0);

    // Asynchronous reset in the middle of a search.
    @(negedge clk);
    vector = onehot(500);
    mode   = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_idx", 32'(idx), 32'd0);
    chk("arst_empty", 32'(err_empty), 32'd0);
    chk("arst_multi", 32'(err_multi), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    req("i7_m0", onehot(7), 1'b0, 0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_indexer.md
# vec_indexer

Sparse-vector-to-index decoder for the LDGM signature datapath; the inverse of the index-to-vector generator. It captures a VEC_LEN-bit sparse vector (bit 0 = index 0) and locates the lowest set bit with a hierarchical search: 50-bit segment steps, then 10-bit block steps, then 1-bit steps. Its mode and latency profile pair with the generator's. It sits between the sparse-matrix row/column storage and the index-domain arithmetic, and also flags empty and multi-hot vectors.

## Interface
- VEC_LEN, 9800, vector length in bits; multiple of SEG, at most 16383
- SEG, 50, coarse stride in bits; multiple of BLK
- BLK, 10, mid stride in bits
- clk  in  1  rising-edge clock
- rst_b  in  1  reset; one clock, asynchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- mode  in  1  0: search starts at BLK stride; 1: search starts at SEG stride
- vector  in  [0:VEC_LEN-1]  sparse input; bit 0 is index 0; sampled on the accepting edge only
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse; result valid
- idx  out  14  index of the lowest set bit
- err_empty  out  1  input vector was all zero
- err_multi  out  1  more than one bit was set

## Operation
- States: IDLE, S50, S10, S1, CHK, DONE. Internal registers: shreg [0:VEC_LEN-1] and base (14 bits).
- IDLE, start=1 (the accepting edge):
  - shreg <= vector; base <= 0; idx, err_empty and err_multi are cleared.
  - If |vector==0: next state DONE with err_empty=1 and idx=0.
  - Otherwise: next state S50 if mode=1, S10 if mode=0.
- S50:
  - If shreg[0:SEG-1]==0: shreg shifts toward bit 0 by SEG with zero fill; base += SEG.
  - Otherwise: go to S10 with no shift.
- S10: same rule using BLK and shreg[0:BLK-1]; on a nonzero window go to S1.
- S1:
  - If shreg[0]==0: shift by 1; base += 1.
  - Otherwise: go to CHK.
- CHK: idx <= base; err_multi <= |shreg[1:VEC_LEN-1]; go to DONE.
- DONE: done=1 for exactly this cycle; next state IDLE.
- The search always terminates because an empty vector never enters S50/S10/S1. The shift windows never run past VEC_LEN-1.
- base never exceeds VEC_LEN-1. All arithmetic is unsigned, 14 bits, with no wrap.
- Multi-hot input: idx reports the lowest set bit, and err_multi=1.
- idx, err_empty and err_multi hold from DONE until the next accepting edge.
- start while busy=1 is ignored; it is neither queued nor able to corrupt the search. start in the DONE cycle is also ignored.
- vector may change freely after the accepting edge.

## Timing
- Reset values (asynchronous assert, any state including mid-search): state=IDLE, busy=0, done=0, idx=0, err_empty=0, err_multi=0, shreg=0, base=0.
- Reset deassertion is synchronized externally. The first start is sampled on the first edge with rst_b=1.
- Let E0 be the accepting edge. DONE is entered at edge E0+L, so done is high in the cycle following that edge.
  - mode=1: L = floor(i/50) + floor((i mod 50)/10) + (i mod 10) + 4
  - mode=0: L = floor(i/10) + (i mod 10) + 3
  - Empty vector: L = 0, i.e. DONE is entered at E0.
- Worst case: i=9799 gives L=212 with mode=1 and L=991 with mode=0.
- busy rises at E0 and falls at the edge leaving DONE.
- Back-to-back: a new start is accepted in the cycle after done at the earliest.

## Test plan
- mode=1, single bit at index 0 -> done at E0+4; idx=0; err_empty=0; err_multi=0.
- Single bit at index 137 -> mode=1: done at E0+16, idx=137. mode=0: done at E0+23, idx=137.
- Single bit at index 9799, mode=1 -> done at E0+212; idx=9799; no flags.
- Bits 42 and 5000 set, mode=1 -> done at E0+10; idx=42; err_multi=1.
- All-zero vector -> done at E0+0 (DONE entered on the accepting edge); idx=0; err_empty=1.
- Robustness, index 500 (mode=1, L=14):
  - Pulse start at E0+3 -> ignored; the original result is unchanged.
  - Assert rst_b=0 at E0+5 -> all outputs 0 immediately (asynchronous).
  - After release, a new start with index 7, mode=0 -> done at E0'+10; idx=7.
